// File: rtl/fpu_pkg.sv
// rtl/fpu_pkg.sv - shared FPU types and constants
package fpu_pkg;

  localparam logic [31:0] CANON_NAN = 32'h7FC00000;
  localparam int          WB_TAG_W  = 6;

  typedef logic [31:0] fp32_t;

  typedef struct packed {
    logic [WB_TAG_W-1:0] tag;
    fp32_t               data;
  } wb_pkt_t;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - register-based synchronous FIFO with wrap-bit pointers
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic [WIDTH-1:0] r_mem [DEPTH];

  // Extra MSB tells full from empty when the index bits match.
  assign empty = (r_wr_ptr == r_rd_ptr);
  assign full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                 (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign head  = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (push) begin
        r_mem[r_wr_ptr[AW-1:0]] <= din;
        r_wr_ptr                <= r_wr_ptr + (AW+1)'(1);
      end
      if (pop) begin
        r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
      end
    end
  end

endmodule

// File: rtl/fdiv_result_collector.sv
// rtl/fdiv_result_collector.sv - credit-gated issue, tag pairing and result buffering for fdiv
module fdiv_result_collector
  import fpu_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int TAG_W = 6
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     issue_valid,
  input  logic [TAG_W-1:0]         issue_tag,
  output logic                     issue_ready,
  output logic                     fu_in_valid,
  input  logic                     fu_out_valid,
  input  logic [31:0]              fu_result,
  output logic                     wb_valid,
  output logic [TAG_W-1:0]         wb_tag,
  output logic [31:0]              wb_data,
  input  logic                     wb_ready,
  output logic [$clog2(DEPTH):0]   occupancy,
  output logic                     err_orphan
);

  localparam int OCC_W = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    fp32_t            data;
  } res_pkt_t;

  logic [OCC_W-1:0] r_occ;
  logic             r_orphan;

  logic             w_issue_fire;
  logic             w_complete;
  logic             w_wb_fire;
  logic             w_tag_full;
  logic             w_tag_empty;
  logic             w_res_full;
  logic             w_res_empty;
  logic [TAG_W-1:0] w_tag_head;
  res_pkt_t         w_res_push;
  res_pkt_t         w_res_head;

  // One credit covers a slot in both FIFOs, so ready depends on the counter alone.
  assign issue_ready  = (r_occ < OCC_W'(DEPTH));
  assign fu_in_valid  = issue_valid & issue_ready;
  assign w_issue_fire = fu_in_valid & ~w_tag_full;
  assign w_complete   = fu_out_valid & ~w_tag_empty & ~w_res_full;
  assign wb_valid     = ~w_res_empty;
  assign w_wb_fire    = wb_valid & wb_ready;

  assign w_res_push.tag  = w_tag_head;
  assign w_res_push.data = fu_result;
  assign wb_tag          = w_res_head.tag;
  assign wb_data         = w_res_head.data;
  assign occupancy       = r_occ;
  assign err_orphan      = r_orphan;

  sync_fifo #(.WIDTH(TAG_W), .DEPTH(DEPTH)) u_tag_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (w_issue_fire),
    .din   (issue_tag),
    .pop   (w_complete),
    .full  (w_tag_full),
    .empty (w_tag_empty),
    .head  (w_tag_head)
  );

  sync_fifo #(.WIDTH(TAG_W+32), .DEPTH(DEPTH)) u_res_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (w_complete),
    .din   (w_res_push),
    .pop   (w_wb_fire),
    .full  (w_res_full),
    .empty (w_res_empty),
    .head  (w_res_head)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_occ    <= '0;
      r_orphan <= 1'b0;
    end else begin
      case ({w_issue_fire, w_wb_fire})
        2'b10:   r_occ <= r_occ + OCC_W'(1);
        2'b01:   r_occ <= r_occ - OCC_W'(1);
        default: r_occ <= r_occ;
      endcase
      // A completion seen with no pending tag is dropped and latched as an error.
      if (fu_out_valid && w_tag_empty) begin
        r_orphan <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fdiv_result_collector.sv
// tb/tb_fdiv_result_collector.sv - directed and scoreboard bench for fdiv_result_collector
module tb_fdiv_result_collector;
  import fpu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        issue_valid;
  logic [5:0]  issue_tag;
  logic        issue_ready;
  logic        fu_in_valid;
  logic        fu_out_valid;
  logic [31:0] fu_result;
  logic        wb_valid;
  logic [5:0]  wb_tag;
  logic [31:0] wb_data;
  logic        wb_ready;
  logic [3:0]  occupancy;
  logic        err_orphan;

  int n_pass  = 0;
  int n_fail  = 0;
  int n_total = 0;

  logic [5:0]  exp_t [3];
  logic [31:0] exp_d [3];
  logic [5:0]  pend [$];
  wb_pkt_t     sb [$];
  wb_pkt_t     exp_p;
  wb_pkt_t     new_p;
  int          cycles;
  int          n_issued;
  int          n_done;

  fdiv_result_collector #(.DEPTH(8), .TAG_W(6)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .issue_valid  (issue_valid),
    .issue_tag    (issue_tag),
    .issue_ready  (issue_ready),
    .fu_in_valid  (fu_in_valid),
    .fu_out_valid (fu_out_valid),
    .fu_result    (fu_result),
    .wb_valid     (wb_valid),
    .wb_tag       (wb_tag),
    .wb_data      (wb_data),
    .wb_ready     (wb_ready),
    .occupancy    (occupancy),
    .err_orphan   (err_orphan)
  );

  initial forever #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [5:0] t);
    issue_valid = 1'b1;
    issue_tag   = t;
    cyc();
    issue_valid = 1'b0;
  endtask

  task automatic complete(input logic [31:0] d);
    fu_out_valid = 1'b1;
    fu_result    = d;
    cyc();
    fu_out_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("reset_orphan_clr", err_orphan, 0);
    chk("reset_occ_clr", occupancy, 0);
    chk("reset_wb_valid_clr", wb_valid, 0);
    cyc();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n        = 1'b0;
    issue_valid  = 1'b0;
    issue_tag    = '0;
    fu_out_valid = 1'b0;
    fu_result    = '0;
    wb_ready     = 1'b0;
    #2;
    chk("rst_issue_ready", issue_ready, 1);
    chk("rst_wb_valid", wb_valid, 0);
    chk("rst_wb_tag", wb_tag, 0);
    chk("rst_wb_data", wb_data, 0);
    chk("rst_occupancy", occupancy, 0);
    chk("rst_err_orphan", err_orphan, 0);
    chk("rst_fu_in_valid_lo", fu_in_valid, 0);
    issue_valid = 1'b1;
    #1;
    chk("rst_fu_in_valid_hi", fu_in_valid, 1);
    issue_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Orphan completion straight after reset
    complete(32'h12345678);
    #1;
    chk("orphan_flag", err_orphan, 1);
    chk("orphan_wb_valid", wb_valid, 0);
    chk("orphan_occ", occupancy, 0);
    cyc();
    chk("orphan_sticky", err_orphan, 1);
    do_reset();

    // Single op, 20-cycle fdiv latency
    issue(6'd5);
    chk("single_occ1", occupancy, 1);
    repeat (19) cyc();
    fu_out_valid = 1'b1;
    fu_result    = 32'h3F800000;
    #1;
    chk("single_no_bypass", wb_valid, 0);
    cyc();
    fu_out_valid = 1'b0;
    chk("single_wb_valid", wb_valid, 1);
    chk("single_wb_tag", wb_tag, 5);
    chk("single_wb_data", wb_data, 32'h3F800000);
    chk("single_occ_held", occupancy, 1);
    wb_ready = 1'b1;
    cyc();
    wb_ready = 1'b0;
    chk("single_occ0", occupancy, 0);
    chk("single_wb_drained", wb_valid, 0);

    // Same-cycle push into an empty tag FIFO cannot satisfy a completion
    issue_valid  = 1'b1;
    issue_tag    = 6'd9;
    fu_out_valid = 1'b1;
    fu_result    = 32'hAAAA5555;
    cyc();
    issue_valid  = 1'b0;
    fu_out_valid = 1'b0;
    chk("samecyc_orphan", err_orphan, 1);
    chk("samecyc_occ", occupancy, 1);
    chk("samecyc_wb_valid", wb_valid, 0);
    complete(32'h7F800001);
    chk("samecyc_tag", wb_tag, 9);
    chk("samecyc_nan_data", wb_data, 32'h7F800001);
    wb_ready = 1'b1;
    cyc();
    wb_ready = 1'b0;
    chk("samecyc_drained", occupancy, 0);
    do_reset();

    // In-order pairing
    exp_t = '{6'd1, 6'd2, 6'd3};
    exp_d = '{32'h40000000, 32'h40400000, 32'h7FC00000};
    for (int i = 0; i < 3; i++) issue(exp_t[i]);
    chk("order_occ3", occupancy, 3);
    for (int i = 0; i < 3; i++) complete(exp_d[i]);
    wb_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("order_wb_valid", wb_valid, 1);
      chk("order_wb_tag", wb_tag, exp_t[i]);
      chk("order_wb_data", wb_data, exp_d[i]);
      cyc();
    end
    wb_ready = 1'b0;
    chk("order_occ0", occupancy, 0);
    chk("order_empty", wb_valid, 0);

    // Full: credit exhausted at DEPTH
    for (int i = 0; i < 8; i++) issue(6'(10 + i));
    for (int i = 0; i < 8; i++) complete(32'h41000000 + i);
    chk("full_occ8", occupancy, 8);
    chk("full_not_ready", issue_ready, 0);
    issue_valid = 1'b1;
    issue_tag   = 6'd40;
    #1;
    chk("full_fu_in_gated", fu_in_valid, 0);
    cyc();
    issue_valid = 1'b0;
    chk("full_occ_hold", occupancy, 8);
    chk("full_head_tag", wb_tag, 10);
    wb_ready = 1'b1;
    cyc();
    wb_ready = 1'b0;
    chk("full_ready_again", issue_ready, 1);
    chk("full_occ7", occupancy, 7);
    chk("full_next_tag", wb_tag, 11);
    chk("full_next_data", wb_data, 32'h41000001);

    // Simultaneous issue and writeback at occupancy 4
    wb_ready = 1'b1;
    repeat (3) cyc();
    wb_ready = 1'b0;
    chk("simul_occ4_pre", occupancy, 4);
    issue_valid = 1'b1;
    issue_tag   = 6'd20;
    wb_ready    = 1'b1;
    cyc();
    issue_valid = 1'b0;
    wb_ready    = 1'b0;
    chk("simul_occ4_post", occupancy, 4);
    chk("simul_head_tag", wb_tag, 15);

    // Reset mid-operation discards everything
    do_reset();
    chk("midrst_ready", issue_ready, 1);

    // Random traffic against an in-order fdiv model
    cycles   = 0;
    n_issued = 0;
    n_done   = 0;
    while (n_done < 10000 && cycles < 40000) begin
      issue_valid  = (n_issued < 10000) && ($urandom_range(0, 3) != 0);
      issue_tag    = 6'($urandom);
      fu_out_valid = (pend.size() > 0) && ($urandom_range(0, 3) != 0);
      fu_result    = $urandom;
      wb_ready     = 1'($urandom_range(0, 1));
      #1;
      chk("rand_occ", occupancy, pend.size() + sb.size());
      chk("rand_ready", issue_ready, (pend.size() + sb.size()) < 8);
      chk("rand_wb_valid", wb_valid, sb.size() != 0);
      if (wb_valid && wb_ready && sb.size() > 0) begin
        exp_p = sb.pop_front();
        chk("rand_wb_pkt", {wb_tag, wb_data}, exp_p);
        n_done++;
      end
      if (fu_out_valid) begin
        new_p.tag  = pend.pop_front();
        new_p.data = fu_result;
        sb.push_back(new_p);
      end
      if (issue_valid && issue_ready) begin
        pend.push_back(issue_tag);
        n_issued++;
      end
      cyc();
      cycles++;
    end
    issue_valid  = 1'b0;
    fu_out_valid = 1'b0;
    wb_ready     = 1'b0;
    #1;
    chk("rand_all_delivered", n_done, 10000);
    chk("rand_no_orphan", err_orphan, 0);
    chk("rand_final_occ", occupancy, 0);
    chk("rand_final_empty", wb_valid, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
